// File: rtl/herald_pkg.sv
// -----------------------------------------------------------------------------
// herald_pkg
// Shared definitions for the Herald command sequencer: FSM state encoding,
// command/result framing sizes and the default completion timeout.
// -----------------------------------------------------------------------------
package herald_pkg;

    // Sequencer states, 3-bit encoding.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_START   = 3'd2,
        ST_WAIT    = 3'd3,
        ST_SEND_HI = 3'd4,
        ST_SEND_LO = 3'd5
    } state_t;

    // Command is opcode + two operands; result is two bytes, MSB first.
    localparam int CMD_BYTES = 3;
    localparam int RES_BYTES = 2;

    // Default number of WAIT cycles before giving up on the core.
    localparam int DEFAULT_TIMEOUT = 255;

endpackage : herald_pkg

// File: rtl/herald_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// herald_cmd_sequencer
// Collects a 3-byte command (opcode, A, B) from the host byte stream, pulses
// core_start once, waits a bounded time for core_done, then returns the 16-bit
// result MSB-first over a valid/ack byte handshake.
//
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   in_data/in_valid  - host command byte stream (single-cycle valid pulses)
//   core_start        - one-cycle launch pulse to the core
//   core_op/a/b       - latched command, held until the next command begins
//   core_done         - core completion pulse (only honoured while waiting)
//   core_result       - core result, valid with core_done
//   out_data/out_valid/out_ack - result byte handshake to host
//   busy              - high whenever not idle
//   err               - sticky error: dropped byte or timeout; cleared by the
//                       first byte of the next command
// All outputs come straight from flops; nothing is combinational from inputs.
// -----------------------------------------------------------------------------
module herald_cmd_sequencer
    import herald_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        core_start,
    output logic [7:0]  core_op,
    output logic [7:0]  core_a,
    output logic [7:0]  core_b,
    input  logic        core_done,
    input  logic [15:0] core_result,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ack,
    output logic        busy,
    output logic        err
);

    localparam int RES_W = RES_BYTES * 8;

    // Last timeout count value before abort, and byte index of the final operand.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
    localparam logic [1:0] LAST_ARG = 2'(CMD_BYTES - 1);

    state_t             state_r;
    state_t             state_next_s;
    logic [1:0]         byte_cnt_r;
    logic [7:0]         tmo_cnt_r;
    logic [RES_W-1:0]   result_r;
    logic [7:0]         op_r;
    logic [7:0]         a_r;
    logic [7:0]         b_r;
    logic               err_r;
    logic               core_start_r;
    logic               out_valid_r;
    logic               busy_r;
    logic [7:0]         out_data_r;
    logic [7:0]         out_data_next_s;
    logic               tmo_hit_s;
    logic               drop_s;
    logic               timeout_abort_s;

    assign tmo_hit_s = (tmo_cnt_r == TMO_LAST);

    // A host byte arriving while a command is in flight is discarded and flagged.
    assign drop_s = in_valid && ((state_r == ST_START)   || (state_r == ST_WAIT) ||
                                 (state_r == ST_SEND_HI) || (state_r == ST_SEND_LO));

    // core_done takes precedence over the timeout in the same cycle.
    assign timeout_abort_s = (state_r == ST_WAIT) && !core_done && tmo_hit_s;

    // Next-state decode for the sequencer FSM.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) state_next_s = ST_LOAD;
                else          state_next_s = ST_IDLE;
            end
            ST_LOAD: begin
                if (in_valid && (byte_cnt_r == LAST_ARG)) state_next_s = ST_START;
                else                                      state_next_s = ST_LOAD;
            end
            ST_START: begin
                state_next_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (core_done)      state_next_s = ST_SEND_HI;
                else if (tmo_hit_s) state_next_s = ST_IDLE;
                else                state_next_s = ST_WAIT;
            end
            ST_SEND_HI: begin
                if (out_ack) state_next_s = ST_SEND_LO;
                else         state_next_s = ST_SEND_HI;
            end
            ST_SEND_LO: begin
                if (out_ack) state_next_s = ST_IDLE;
                else         state_next_s = ST_SEND_LO;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Byte to present next cycle; entering SEND_HI takes the high byte straight
    // from core_result because result_r is loaded on that same edge.
    always_comb begin
        out_data_next_s = 8'h00;
        if (state_next_s == ST_SEND_HI) begin
            if (state_r == ST_WAIT) out_data_next_s = core_result[15:8];
            else                    out_data_next_s = result_r[15:8];
        end else if (state_next_s == ST_SEND_LO) begin
            out_data_next_s = result_r[7:0];
        end else begin
            out_data_next_s = 8'h00;
        end
    end

    // FSM state, command capture, byte/timeout counters and result latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            byte_cnt_r <= 2'd0;
            tmo_cnt_r  <= 8'd0;
            result_r   <= '0;
            op_r       <= 8'h00;
            a_r        <= 8'h00;
            b_r        <= 8'h00;
        end else begin
            state_r <= state_next_s;
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_r       <= in_data;
                        byte_cnt_r <= 2'd1;
                    end
                end
                ST_LOAD: begin
                    if (in_valid) begin
                        if (byte_cnt_r == 2'd1) a_r <= in_data;
                        else                    b_r <= in_data;
                        if (byte_cnt_r == LAST_ARG) byte_cnt_r <= 2'd0;
                        else                        byte_cnt_r <= byte_cnt_r + 2'd1;
                    end
                end
                ST_START: begin
                    tmo_cnt_r <= 8'd0;
                end
                ST_WAIT: begin
                    tmo_cnt_r <= tmo_cnt_r + 8'd1;
                    if (core_done) result_r <= core_result;
                end
                default: begin
                end
            endcase
        end
    end

    // Sticky error flag: set on dropped byte or timeout, cleared by a new command.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if ((state_r == ST_IDLE) && in_valid) begin
            err_r <= 1'b0;
        end else if (drop_s || timeout_abort_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    // Output flops, loaded from the next state so they line up with the FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            core_start_r <= 1'b0;
            busy_r       <= 1'b0;
            out_valid_r  <= 1'b0;
            out_data_r   <= 8'h00;
        end else begin
            core_start_r <= (state_next_s == ST_START);
            busy_r       <= (state_next_s != ST_IDLE);
            out_valid_r  <= (state_next_s == ST_SEND_HI) || (state_next_s == ST_SEND_LO);
            out_data_r   <= out_data_next_s;
        end
    end

    assign core_start = core_start_r;
    assign core_op    = op_r;
    assign core_a     = a_r;
    assign core_b     = b_r;
    assign out_data   = out_data_r;
    assign out_valid  = out_valid_r;
    assign busy       = busy_r;
    assign err        = err_r;

endmodule : herald_cmd_sequencer

// File: tb/tb_herald_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_herald_cmd_sequencer
// Directed bench with a transaction-level reference model (bytes collected,
// pending start, elapsed wait cycles, queue of result bytes still owed) that is
// checked against the DUT every cycle, plus hand-computed literal checks.
// -----------------------------------------------------------------------------
module tb_herald_cmd_sequencer;

    localparam int TMO = 255;

    logic        clk;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        core_start;
    logic [7:0]  core_op;
    logic [7:0]  core_a;
    logic [7:0]  core_b;
    logic        core_done;
    logic [15:0] core_result;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ack;
    logic        busy;
    logic        err;

    int compared   = 0;
    int mismatched = 0;

    herald_cmd_sequencer #(.TIMEOUT(TMO)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .core_start  (core_start),
        .core_op     (core_op),
        .core_a      (core_a),
        .core_b      (core_b),
        .core_done   (core_done),
        .core_result (core_result),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ack     (out_ack),
        .busy        (busy),
        .err         (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int         m_got;        // command bytes collected so far (0..2)
    bit         m_start;      // launch pulse owed this cycle
    bit         m_waiting;    // core running
    int         m_wait_cyc;   // cycles spent waiting so far
    logic [7:0] m_q[$];       // result bytes still to deliver
    bit         m_err;
    logic [7:0] m_op, m_a, m_b;

    task automatic model_reset();
        m_got = 0; m_start = 0; m_waiting = 0; m_wait_cyc = 0;
        m_q.delete(); m_err = 0; m_op = 8'h00; m_a = 8'h00; m_b = 8'h00;
    endtask

    task automatic model_step();
        if (rst) begin
            model_reset();
        end else if (m_q.size() > 0) begin
            if (in_valid) m_err = 1;
            if (out_ack) void'(m_q.pop_front());
        end else if (m_waiting) begin
            if (in_valid) m_err = 1;
            m_wait_cyc++;
            if (core_done) begin
                m_waiting = 0;
                m_q.push_back(core_result[15:8]);
                m_q.push_back(core_result[7:0]);
            end else if (m_wait_cyc == TMO) begin
                m_waiting = 0;
                m_err = 1;
            end
        end else if (m_start) begin
            if (in_valid) m_err = 1;
            m_start = 0;
            m_waiting = 1;
            m_wait_cyc = 0;
        end else if (in_valid) begin
            if (m_got == 0) begin m_op = in_data; m_err = 0; end
            else if (m_got == 1) m_a = in_data;
            else m_b = in_data;
            m_got++;
            if (m_got == 3) begin m_got = 0; m_start = 1; end
        end
    endtask

    // Model advances on each edge with the inputs the DUT sampled; compare just after.
    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            model_step();
            #1;
            chk("m_core_start", {15'd0, core_start}, {15'd0, m_start});
            chk("m_busy", {15'd0, busy},
                {15'd0, (m_got != 0) || m_start || m_waiting || (m_q.size() > 0)});
            chk("m_out_valid", {15'd0, out_valid}, {15'd0, m_q.size() > 0});
            if (m_q.size() > 0) chk("m_out_data", {8'd0, out_data}, {8'd0, m_q[0]});
            chk("m_err", {15'd0, err}, {15'd0, m_err});
            chk("m_core_op", {8'd0, core_op}, {8'd0, m_op});
            chk("m_core_a", {8'd0, core_a}, {8'd0, m_a});
            chk("m_core_b", {8'd0, core_b}, {8'd0, m_b});
        end
    end

    // ---------------- stimulus (always entered and left on a negedge) ----------------
    task automatic send1(input logic [7:0] b);
        in_valid = 1'b1; in_data = b;
        @(negedge clk);
        in_valid = 1'b0; in_data = 8'h00;
    endtask

    task automatic send3(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        in_valid = 1'b1; in_data = b0;
        @(negedge clk); in_data = b1;
        @(negedge clk); in_data = b2;
        @(negedge clk); in_valid = 1'b0; in_data = 8'h00;
    endtask

    initial begin
        rst = 1'b1; in_data = 8'h00; in_valid = 1'b0;
        core_done = 1'b0; core_result = 16'h0000; out_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {15'd0, busy}, 16'h0000);
        chk("rst_err", {15'd0, err}, 16'h0000);
        chk("rst_out_valid", {15'd0, out_valid}, 16'h0000);
        chk("rst_core_op", {8'd0, core_op}, 16'h0000);
        rst = 1'b0;
        @(negedge clk);

        // Basic command 01/12/34 -> BEEF, back-to-back acks.
        send3(8'h01, 8'h12, 8'h34);
        chk("t1_start", {15'd0, core_start}, 16'h0001);
        chk("t1_op", {8'd0, core_op}, 16'h0001);
        chk("t1_a", {8'd0, core_a}, 16'h0012);
        chk("t1_b", {8'd0, core_b}, 16'h0034);
        @(negedge clk);
        chk("t1_start_single", {15'd0, core_start}, 16'h0000);
        core_done = 1'b1; core_result = 16'hBEEF;
        @(negedge clk);
        core_done = 1'b0;
        chk("t1_valid_hi", {15'd0, out_valid}, 16'h0001);
        chk("t1_data_hi", {8'd0, out_data}, 16'h00BE);
        out_ack = 1'b1;
        @(negedge clk);
        chk("t1_data_lo", {8'd0, out_data}, 16'h00EF);
        chk("t1_valid_lo", {15'd0, out_valid}, 16'h0001);
        @(negedge clk);
        out_ack = 1'b0;
        chk("t1_valid_end", {15'd0, out_valid}, 16'h0000);
        chk("t1_busy_end", {15'd0, busy}, 16'h0000);

        // Host stalls 5 cycles in SEND_HI.
        send3(8'h02, 8'h03, 8'h04);
        @(negedge clk);
        core_done = 1'b1; core_result = 16'h1357;
        @(negedge clk);
        core_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("t2_hold_valid", {15'd0, out_valid}, 16'h0001);
            chk("t2_hold_data", {8'd0, out_data}, 16'h0013);
            @(negedge clk);
        end
        out_ack = 1'b1;
        @(negedge clk);
        out_ack = 1'b0;
        chk("t2_single_xfer", {8'd0, out_data}, 16'h0057);
        @(negedge clk);
        chk("t2_lo_held", {15'd0, out_valid}, 16'h0001);
        out_ack = 1'b1;
        @(negedge clk);
        out_ack = 1'b0;
        chk("t2_done", {15'd0, out_valid}, 16'h0000);

        // Timeout: WAIT lasts exactly TMO cycles, err the cycle after.
        send3(8'h07, 8'h08, 8'h09);
        for (int i = 1; i <= TMO; i++) begin
            @(negedge clk);
            chk("t3_wait_busy", {15'd0, busy}, 16'h0001);
            chk("t3_wait_err", {15'd0, err}, 16'h0000);
        end
        @(negedge clk);
        chk("t3_tmo_busy", {15'd0, busy}, 16'h0000);
        chk("t3_tmo_err", {15'd0, err}, 16'h0001);
        send1(8'h05);
        chk("t3_err_clear", {15'd0, err}, 16'h0000);
        chk("t3_new_op", {8'd0, core_op}, 16'h0005);
        send1(8'h66);
        send1(8'h77);
        chk("t4_start", {15'd0, core_start}, 16'h0001);

        // Byte dropped during WAIT, then normal completion.
        @(negedge clk);
        send1(8'hAA);
        chk("t4_drop_err", {15'd0, err}, 16'h0001);
        chk("t4_drop_op", {8'd0, core_op}, 16'h0005);
        chk("t4_drop_a", {8'd0, core_a}, 16'h0066);
        chk("t4_drop_b", {8'd0, core_b}, 16'h0077);
        core_done = 1'b1; core_result = 16'hA55A;
        @(negedge clk);
        core_done = 1'b0;
        chk("t4_data_hi", {8'd0, out_data}, 16'h00A5);
        chk("t4_valid", {15'd0, out_valid}, 16'h0001);
        out_ack = 1'b1;
        @(negedge clk);
        chk("t4_data_lo", {8'd0, out_data}, 16'h005A);
        @(negedge clk);
        out_ack = 1'b0;
        chk("t4_end", {15'd0, out_valid}, 16'h0000);

        // core_done on the final timeout cycle wins.
        send3(8'h0A, 8'h0B, 8'h0C);
        chk("t5_err_cleared", {15'd0, err}, 16'h0000);
        repeat (TMO - 1) @(negedge clk);
        @(negedge clk);
        core_done = 1'b1; core_result = 16'hC0DE;
        @(negedge clk);
        core_done = 1'b0;
        chk("t5_valid", {15'd0, out_valid}, 16'h0001);
        chk("t5_data_hi", {8'd0, out_data}, 16'h00C0);
        chk("t5_err", {15'd0, err}, 16'h0000);
        out_ack = 1'b1;
        @(negedge clk);
        chk("t5_data_lo", {8'd0, out_data}, 16'h00DE);
        @(negedge clk);
        out_ack = 1'b0;
        chk("t5_end_err", {15'd0, err}, 16'h0000);

        // Reset while in SEND_LO, then a fresh command.
        send3(8'h11, 8'h22, 8'h33);
        @(negedge clk);
        core_done = 1'b1; core_result = 16'h1234;
        @(negedge clk);
        core_done = 1'b0;
        out_ack = 1'b1;
        @(negedge clk);
        out_ack = 1'b0;
        chk("t6_in_lo", {8'd0, out_data}, 16'h0034);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_valid", {15'd0, out_valid}, 16'h0000);
        chk("t6_busy", {15'd0, busy}, 16'h0000);
        chk("t6_op", {8'd0, core_op}, 16'h0000);
        chk("t6_a", {8'd0, core_a}, 16'h0000);
        chk("t6_b", {8'd0, core_b}, 16'h0000);
        send3(8'h21, 8'h43, 8'h65);
        chk("t6_fresh_start", {15'd0, core_start}, 16'h0001);
        chk("t6_fresh_op", {8'd0, core_op}, 16'h0021);
        core_done = 1'b1; core_result = 16'h9876;
        @(negedge clk);
        core_done = 1'b0;
        chk("t6_start_ignores_done", {15'd0, out_valid}, 16'h0000);
        @(negedge clk);
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        chk("t6_fresh_hi", {8'd0, out_data}, 16'h0098);
        out_ack = 1'b1;
        @(negedge clk);
        chk("t6_fresh_lo", {8'd0, out_data}, 16'h0076);
        @(negedge clk);
        out_ack = 1'b0;
        chk("t6_fresh_end", {15'd0, busy}, 16'h0000);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_herald_cmd_sequencer
